uart_report_sched: RTL

- Round-robin scheduler that shares one UART byte transmitter between N_REQ report sources in the GPSDO (e.g. frequency count, phase error, DAC word, status).
- Each source posts a 32-bit word.
- Block frames it as header, source ID, 4 data bytes MSB first, and optional checksum.
- Bytes are fed to the UART TX one at a time using the uart_en / uart_tx_busy handshake.

---
 rtl/uart_report_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_report_sched.sv
// rtl/uart_report_sched.sv - round-robin framer sharing one UART byte transmitter between report sources
// Optional checksum byte enabled by defining UART_REPORT_SCHED_CHKSUM_EN.
module uart_report_sched #(
  parameter int unsigned N_REQ    = 4,
  parameter logic [7:0]  HDR_BYTE = 8'hA5,
  parameter int unsigned BUSY_TO  = 16
) (
  input  logic                 CLK_SYS,
  input  logic                 CLK_RST,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  req_data,
  input  logic                 uart_tx_busy,
  output logic                 uart_en,
  output logic [7:0]           uart_din,
  output logic [2:0]           grant_id,
  output logic                 sched_busy,
  output logic [N_REQ-1:0]     req_ovf
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(BUSY_TO) + 1;
`ifdef UART_REPORT_SCHED_CHKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd5;
`endif

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t            state_q;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [N_REQ-1:0]  req_ovf_q, req_ovf_d;
  logic [31:0]       slot_q [N_REQ];
  logic [31:0]       frame_data_q;
  logic [IW-1:0]     last_grant_q;
  logic [IW-1:0]     gnt_idx_d, cand_idx_d;
  int                cand_d;
  logic              gnt_vld_d, capture_d;
  logic [2:0]        grant_id_q, byte_idx_q, nxt_idx_d;
  logic [7:0]        uart_din_q, nxt_byte_d;
  logic              uart_en_q, sched_busy_q;
  logic [CW-1:0]     to_cnt_q;

  // Scan upward from last_grant+1; the lowest offset wins because it is visited last.
  always_comb begin
    gnt_vld_d  = 1'b0;
    gnt_idx_d  = '0;
    cand_d     = 0;
    cand_idx_d = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      cand_d     = (int'(last_grant_q) + k) % int'(N_REQ);
      cand_idx_d = IW'(cand_d);
      if (pending_q[cand_idx_d]) begin
        gnt_vld_d = 1'b1;
        gnt_idx_d = cand_idx_d;
      end
    end
  end

  assign capture_d = (state_q == IDLE) && gnt_vld_d;

  // A post that lands on the slot being captured refills it without counting as overflow.
  always_comb begin
    pending_d = pending_q;
    req_ovf_d = req & pending_q;
    if (capture_d) begin
      pending_d[gnt_idx_d] = 1'b0;
      req_ovf_d[gnt_idx_d] = 1'b0;
    end
    pending_d = pending_d | req;
  end

`ifdef UART_REPORT_SCHED_CHKSUM_EN
  logic [7:0] chksum_d;
  assign chksum_d = {5'b0, grant_id_q} ^ frame_data_q[31:24] ^ frame_data_q[23:16]
                  ^ frame_data_q[15:8] ^ frame_data_q[7:0];
`endif

  always_comb begin
    nxt_idx_d  = byte_idx_q + 3'd1;
    nxt_byte_d = HDR_BYTE;
    case (nxt_idx_d)
      3'd1:    nxt_byte_d = {5'b0, grant_id_q};
      3'd2:    nxt_byte_d = frame_data_q[31:24];
      3'd3:    nxt_byte_d = frame_data_q[23:16];
      3'd4:    nxt_byte_d = frame_data_q[15:8];
      3'd5:    nxt_byte_d = frame_data_q[7:0];
`ifdef UART_REPORT_SCHED_CHKSUM_EN
      3'd6:    nxt_byte_d = chksum_d;
`endif
      default: nxt_byte_d = HDR_BYTE;
    endcase
  end

  always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
    if (CLK_RST) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      req_ovf_q    <= '0;
      for (int i = 0; i < int'(N_REQ); i++) slot_q[i] <= '0;
      frame_data_q <= '0;
      last_grant_q <= IW'(N_REQ - 1);
      grant_id_q   <= '0;
      byte_idx_q   <= '0;
      uart_din_q   <= '0;
      uart_en_q    <= 1'b0;
      sched_busy_q <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      req_ovf_q <= req_ovf_d;
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (req[i]) slot_q[i] <= req_data[32*i +: 32];
      end
      uart_en_q <= 1'b0;
      // uart_en is raised on every transition into SEND, so it is high exactly during SEND.
      case (state_q)
        IDLE: begin
          if (gnt_vld_d) begin
            frame_data_q <= slot_q[gnt_idx_d];
            grant_id_q   <= 3'(gnt_idx_d);
            last_grant_q <= gnt_idx_d;
            sched_busy_q <= 1'b1;
            byte_idx_q   <= '0;
            uart_din_q   <= HDR_BYTE;
            uart_en_q    <= 1'b1;
            state_q      <= SEND;
          end
        end
        SEND: begin
          to_cnt_q <= CW'(1);
          state_q  <= WAIT_HI;
        end
        WAIT_HI: begin
          if (uart_tx_busy) begin
            state_q <= WAIT_LO;
          end else if (to_cnt_q == CW'(BUSY_TO - 1)) begin
            uart_en_q <= 1'b1;
            state_q   <= SEND;
          end else begin
            to_cnt_q <= to_cnt_q + CW'(1);
          end
        end
        WAIT_LO: begin
          if (!uart_tx_busy) begin
            if (byte_idx_q == LAST_IDX) begin
              sched_busy_q <= 1'b0;
              state_q      <= IDLE;
            end else begin
              byte_idx_q <= nxt_idx_d;
              uart_din_q <= nxt_byte_d;
              uart_en_q  <= 1'b1;
              state_q    <= SEND;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_en    = uart_en_q;
  assign uart_din   = uart_din_q;
  assign grant_id   = grant_id_q;
  assign sched_busy = sched_busy_q;
  assign req_ovf    = req_ovf_q;

endmodule
